// File: rtl/wb_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
package wb_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 64;
  localparam int DEFAULT_REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [DEFAULT_REG_ADDR_WIDTH-1:0] rd;
    logic [DEFAULT_DATA_WIDTH-1:0]     data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_SIDE
  } grant_t;

endpackage

// File: rtl/wb_starve_ctr.sv
// Saturating count of consecutive arbitrations lost by the side requester.
module wb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && cnt != CW'(LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign at_limit = (cnt == CW'(LIMIT));

endmodule

// File: rtl/wb_arbiter.sv
// Shares the single register-file write port between MEM/WB writeback and one
// long-latency side requester, with same-rd ordering and bounded starvation.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pipe_valid,
  input  logic [REG_ADDR_WIDTH-1:0] pipe_rd,
  input  logic [DATA_WIDTH-1:0]     pipe_data,
  output logic                      pipe_stall,
  input  logic                      side_valid,
  input  logic [REG_ADDR_WIDTH-1:0] side_rd,
  input  logic [DATA_WIDTH-1:0]     side_data,
  output logic                      side_ready,
  output logic                      rf_wen,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata
);

  // Same layout as wb_req_t, sized to this instance's parameters.
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     data;
  } req_t;

  grant_t grant;
  req_t   win;
  logic   conflict;
  logic   at_limit;
  logic   starve_inc;

  // rd==0 on the side never counts as a conflict, so x0 writes follow normal priority.
  assign conflict = (pipe_rd == side_rd) && (side_rd != '0);

  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      if (side_valid && (!pipe_valid || conflict || at_limit)) begin
        grant = GNT_SIDE;
      end else if (pipe_valid) begin
        grant = GNT_PIPE;
      end
    end
  end

  always_comb begin
    win = '{rd: pipe_rd, data: pipe_data};
    if (grant == GNT_SIDE) begin
      win = '{rd: side_rd, data: side_data};
    end
  end

  assign side_ready = (grant == GNT_SIDE);
  assign pipe_stall = side_ready && pipe_valid;
  assign starve_inc = side_valid && !side_ready;

  wb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .reset    (reset),
    .inc      (starve_inc),
    .clr      (!starve_inc),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= (grant != GNT_NONE) && (win.rd != '0);
      if (grant != GNT_NONE) begin
        rf_waddr <= win.rd;
        rf_wdata <= win.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized
// run against a rule-level reference model.
module tb_wb_arbiter;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pipe_valid;
  logic [AW-1:0] pipe_rd;
  logic [DW-1:0] pipe_data;
  logic          pipe_stall;
  logic          side_valid;
  logic [AW-1:0] side_rd;
  logic [DW-1:0] side_data;
  logic          side_ready;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (AW),
    .STARVE_LIMIT   (LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .pipe_stall (pipe_stall),
    .side_valid (side_valid),
    .side_rd    (side_rd),
    .side_data  (side_data),
    .side_ready (side_ready),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_valid = 1'b0;
    side_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 64'h1234;
    side_valid = 1'b1; side_rd = 5'd4; side_data = 64'h5678;
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (side_ready !== 1'b0 || pipe_stall !== 1'b0) begin
        failed++;
        $display("FAIL reset_comb cyc%0d: side_ready=%b pipe_stall=%b, want 0 0", c, side_ready, pipe_stall);
      end
      tests++;
      if (rf_wen !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
        failed++;
        $display("FAIL reset_regs cyc%0d: wen=%b waddr=%0d wdata=%h, want all 0", c, rf_wen, rf_waddr, rf_wdata);
      end
      tick();
    end
    reset = 1'b0;
    #1;
    tests++;
    if (rf_wen !== 1'b0) begin
      failed++;
      $display("FAIL reset_release: rf_wen=%b, want 0", rf_wen);
    end
    idle();
    idle();
  endtask

  task automatic test_pipe_alone();
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 64'hAA;
    side_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (pipe_stall !== 1'b0 || side_ready !== 1'b0) begin
      failed++;
      $display("FAIL pipe_alone_comb: stall=%b side_ready=%b, want 0 0", pipe_stall, side_ready);
    end
    tick();
    pipe_valid = 1'b0;
    tests++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'hAA) begin
      failed++;
      $display("FAIL pipe_alone_write: wen=%b waddr=%0d wdata=%h, want 1 5 aa", rf_wen, rf_waddr, rf_wdata);
    end
    idle();
  endtask

  task automatic test_starvation();
    logic [DW-1:0] pd;
    side_valid = 1'b1; side_rd = 5'd7; side_data = 64'h77;
    for (int c = 0; c <= LIMIT; c++) begin
      pd = {$urandom, $urandom};
      pipe_valid = 1'b1; pipe_rd = AW'(c + 1); pipe_data = pd;
      @(negedge clk);
      tests++;
      if (side_ready !== (c == LIMIT) || pipe_stall !== (c == LIMIT)) begin
        failed++;
        $display("FAIL starve_grant cyc%0d: side_ready=%b stall=%b, want %b %b",
                 c, side_ready, pipe_stall, c == LIMIT, c == LIMIT);
      end
      tick();
      if (c < LIMIT) begin
        tests++;
        if (rf_wen !== 1'b1 || rf_waddr !== AW'(c + 1) || rf_wdata !== pd) begin
          failed++;
          $display("FAIL starve_pipe_write cyc%0d: wen=%b waddr=%0d wdata=%h, want 1 %0d %h",
                   c, rf_wen, rf_waddr, rf_wdata, c + 1, pd);
        end
      end else begin
        tests++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 64'h77) begin
          failed++;
          $display("FAIL starve_side_write: wen=%b waddr=%0d wdata=%h, want 1 7 77", rf_wen, rf_waddr, rf_wdata);
        end
      end
    end
    // stalled pipe request re-presented unchanged
    side_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (pipe_stall !== 1'b0) begin
      failed++;
      $display("FAIL starve_repipe_stall: stall=%b, want 0", pipe_stall);
    end
    tick();
    tests++;
    if (rf_wen !== 1'b1 || rf_waddr !== AW'(LIMIT + 1) || rf_wdata !== pd) begin
      failed++;
      $display("FAIL starve_repipe_write: wen=%b waddr=%0d, want 1 %0d", rf_wen, rf_waddr, LIMIT + 1);
    end
    idle();
  endtask

  task automatic test_same_rd();
    pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 64'h22;
    side_valid = 1'b1; side_rd = 5'd9; side_data = 64'h11;
    @(negedge clk);
    tests++;
    if (side_ready !== 1'b1 || pipe_stall !== 1'b1) begin
      failed++;
      $display("FAIL same_rd_grant: side_ready=%b stall=%b, want 1 1", side_ready, pipe_stall);
    end
    tick();
    side_valid = 1'b0;
    tests++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 64'h11) begin
      failed++;
      $display("FAIL same_rd_first: wen=%b waddr=%0d wdata=%h, want 1 9 11", rf_wen, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    tests++;
    if (pipe_stall !== 1'b0) begin
      failed++;
      $display("FAIL same_rd_second_stall: stall=%b, want 0", pipe_stall);
    end
    tick();
    tests++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 64'h22) begin
      failed++;
      $display("FAIL same_rd_second: wen=%b waddr=%0d wdata=%h, want 1 9 22", rf_wen, rf_waddr, rf_wdata);
    end
    idle();
  endtask

  task automatic test_x0();
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 64'hBEEF;
    side_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (pipe_stall !== 1'b0) begin
      failed++;
      $display("FAIL x0_pipe_stall: stall=%b, want 0", pipe_stall);
    end
    tick();
    tests++;
    if (rf_wen !== 1'b0) begin
      failed++;
      $display("FAIL x0_pipe_wen: rf_wen=%b, want 0", rf_wen);
    end
    side_valid = 1'b1; side_rd = 5'd0; side_data = 64'hCAFE;
    @(negedge clk);
    tests++;
    if (side_ready !== 1'b0 || pipe_stall !== 1'b0) begin
      failed++;
      $display("FAIL x0_both_grant: side_ready=%b stall=%b, want 0 0", side_ready, pipe_stall);
    end
    tick();
    pipe_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (side_ready !== 1'b1) begin
      failed++;
      $display("FAIL x0_side_grant: side_ready=%b, want 1", side_ready);
    end
    tick();
    tests++;
    if (rf_wen !== 1'b0) begin
      failed++;
      $display("FAIL x0_side_wen: rf_wen=%b, want 0", rf_wen);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    side_valid = 1'b1; side_rd = 5'd7; side_data = 64'h99;
    pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 64'h1;
    for (int c = 0; c < 3; c++) tick();
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (side_ready !== 1'b0 || pipe_stall !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_comb: side_ready=%b stall=%b, want 0 0", side_ready, pipe_stall);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c <= LIMIT; c++) begin
      @(negedge clk);
      tests++;
      if (side_ready !== (c == LIMIT)) begin
        failed++;
        $display("FAIL reset_mid_regrant cyc%0d: side_ready=%b, want %b", c, side_ready, c == LIMIT);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_random(input int n);
    int            lost = 0;
    logic          ps = 1'b0;
    logic          exp_side, exp_stall, exp_wen;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    for (int i = 0; i < n; i++) begin
      if (!ps) begin
        pipe_valid = ($urandom_range(0, 9) < 7);
        pipe_rd    = AW'($urandom_range(0, 3));
        pipe_data  = {$urandom, $urandom};
      end
      if (!side_valid && $urandom_range(0, 1) == 1) begin
        side_valid = 1'b1;
        side_rd    = AW'($urandom_range(0, 3));
        side_data  = {$urandom, $urandom};
      end
      exp_side  = side_valid && (!pipe_valid || (pipe_rd == side_rd && side_rd != 0) || lost >= LIMIT);
      exp_stall = exp_side && pipe_valid;
      if (exp_side) begin
        exp_wen = (side_rd != 0); exp_addr = side_rd; exp_data = side_data;
      end else begin
        exp_wen = pipe_valid && (pipe_rd != 0); exp_addr = pipe_rd; exp_data = pipe_data;
      end
      @(negedge clk);
      tests++;
      if (side_ready !== exp_side || pipe_stall !== exp_stall) begin
        failed++;
        $display("FAIL rand_grant i=%0d: side_ready=%b stall=%b, want %b %b", i, side_ready, pipe_stall, exp_side, exp_stall);
      end
      lost = (side_valid && !exp_side) ? ((lost < LIMIT) ? lost + 1 : LIMIT) : 0;
      tick();
      tests++;
      if (rf_wen !== exp_wen || (exp_wen && (rf_waddr !== exp_addr || rf_wdata !== exp_data))) begin
        failed++;
        $display("FAIL rand_write i=%0d: wen=%b waddr=%0d wdata=%h, want %b %0d %h",
                 i, rf_wen, rf_waddr, rf_wdata, exp_wen, exp_addr, exp_data);
      end
      if (exp_side) side_valid = 1'b0;
      ps = exp_stall;
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    side_valid = 1'b0; side_rd = '0; side_data = '0;
    test_reset();
    test_pipe_alone();
    test_starvation();
    test_same_rd();
    test_x0();
    test_reset_mid();
    test_random(400);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Arbiter and sequencer for the single register-file write port. It sits directly after the MEM/WB pipeline registers. It shares the write port between the in-order pipeline's writeback (from MEM/WB) and one out-of-band long-latency requester (divider / load-miss return). It stalls the pipeline when the side requester must win, guarantees older-first ordering on same-destination conflicts, and bounds side-requester starvation with a counter.

## Interface
Parameters:
- DATA_WIDTH, 64, write data width
- REG_ADDR_WIDTH, 5, register index width
- STARVE_LIMIT, 4, maximum consecutive lost arbitrations for the side requester; legal 1..15

Ports:
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- pipe_valid  in  1  MEM/WB holds a register-writing instruction
- pipe_rd  in  REG_ADDR_WIDTH  MEM/WB destination register
- pipe_data  in  DATA_WIDTH  MEM/WB writeback value (ALU or memory data, already muxed)
- pipe_stall  out  1  hold MEM/WB and all upstream stage registers this cycle
- side_valid  in  1  long-latency result pending
- side_rd  in  REG_ADDR_WIDTH  side destination register
- side_data  in  DATA_WIDTH  side result
- side_ready  out  1  side result accepted this cycle
- rf_wen  out  1  register-file write enable (registered)
- rf_waddr  out  REG_ADDR_WIDTH  write address (registered)
- rf_wdata  out  DATA_WIDTH  write data (registered)

## Operation
- Grant decision is per cycle. At most one of {pipe, side} is granted.
  - Only pipe_valid: pipe granted; pipe_stall=0.
  - Only side_valid: side granted; side_ready=1.
  - Both valid, pipe_rd==side_rd, rd≠0: side granted, pipe_stall=1. The side instruction is older, so the younger pipe write lands one cycle later.
  - Both valid, starve_cnt==STARVE_LIMIT: side granted, pipe_stall=1.
  - Both valid otherwise: pipe granted; side_ready=0.
- Granted rd==0: request is consumed (pipe not stalled / side_ready=1) and rf_wen=0 next cycle. Rule order: an rd==0 side request never triggers the same-rd conflict rule.
- Starvation counter starve_cnt:
  - Saturating, width $clog2(STARVE_LIMIT+1).
  - Increments when side_valid && !side_ready.
  - Clears when side_ready=1 or side_valid=0.
- Side handshake: side_valid, side_rd and side_data must stay stable until side_ready. The arbiter never drops an asserted side request.
- pipe_stall is asserted only when pipe_valid=1 and the side is granted. It is never asserted with pipe_valid=0.
- Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, starve_cnt=0.
- Combinational outputs during reset: side_ready=0, pipe_stall=0, regardless of inputs.

## Timing
- pipe_stall and side_ready are combinational from the current inputs and starve_cnt, valid in the same cycle.
- Write latency: a request granted in cycle N gives rf_wen/rf_waddr/rf_wdata in cycle N+1. The register file commits at the N+1→N+2 edge.
- Throughput: one write per cycle. A continuous side stream with a continuous pipe stream yields STARVE_LIMIT pipe grants followed by 1 side grant, repeating.
- Reset mid-operation: in the cycle reset is high, no grant is issued. Outputs clear at the next edge and the pending side request is re-arbitrated from starve_cnt=0.
- A stalled pipe request is re-presented unchanged in the next cycle. The arbiter does not buffer it.

## Structure
- Shared package wb_pkg:
  - typedef wb_req_t {logic [REG_ADDR_WIDTH-1:0] rd; logic [DATA_WIDTH-1:0] data;}
  - enum grant_t {GNT_NONE, GNT_PIPE, GNT_SIDE}
  - default DATA_WIDTH / REG_ADDR_WIDTH constants
- Sub-module wb_starve_ctr: saturating counter with inc/clr inputs and an at_limit output.
- The top level holds the grant logic and output registers.

## Test plan
- Reset: hold reset 3 cycles with both requesters valid → rf_wen=0, side_ready=0, pipe_stall=0 throughout, and rf_wen=0 in the cycle after release.
- Pipe alone: cycle N pipe_valid, rd=5, data=0xAA → cycle N+1 rf_wen=1, waddr=5, wdata=0xAA; pipe_stall never asserted.
- Starvation, STARVE_LIMIT=4: pipe continuously valid (rd=1..), side valid rd=7, data=0x77 from cycle 0 → pipe granted cycles 0–3, side_ready=1 and pipe_stall=1 in cycle 4, rf_waddr=7 in cycle 5.
- Same-rd ordering: both valid, rd=9, side=0x11, pipe=0x22 → side granted with stall, then pipe granted next cycle; successive writes 0x11 then 0x22 to r9.
- x0 handling: pipe rd=0 → no stall, rf_wen=0 next cycle. Side rd=0 with pipe rd=0 → pipe granted (no conflict rule); side then granted with rf_wen=0.
- Reset mid-contention: assert reset when starve_cnt=3 → after release, the side needs another full STARVE_LIMIT lost cycles before a forced grant.
